mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single 256-bit line-wide data memory between the data cache (port 0) and the instruction cache (port 1).
- Sits between both caches' memory interfaces and the data memory.
- Arbitrates round-robin and latches the winner's request.
- Holds the memory-side signals stable until the memory acknowledges, then steers the acknowledge back to the winning cache only.
- Keeps per-port saturating grant counters for performance monitoring.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide data memory between the data cache (port 0)
// and the instruction cache (port 1).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   pN_enable_i           port N request, held until its ack
//   pN_write_i            port N direction (1 = write line, 0 = read line)
//   pN_addr_i/pN_data_i   port N line address / write data
//   pN_ack_o              port N transaction done (combinational)
//   pN_data_o             read data to port N (memory read data, ungated)
//   mem_enable_o          registered memory request
//   mem_write_o           registered memory write strobe
//   mem_addr_o/mem_data_o registered memory address / write data
//   mem_ack_i/mem_data_i  memory done / read data (valid in the ack cycle only)
//   pN_grants_o           saturating count of completed port N transactions
//
// Round-robin arbitration in IDLE latches the winner's request onto the memory
// side; BUSY holds it until mem_ack_i, which is steered to the winner only.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [CNT_W-1:0]  p0_grants_o,
  output logic [CNT_W-1:0]  p1_grants_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              r_state, w_state_next;
  // Port that won the most recent arbitration; while BUSY it is also the owner.
  logic                r_last_grant, w_last_grant_next;
  logic                r_mem_enable, w_mem_enable_next;
  logic                r_mem_write, w_mem_write_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0]   r_mem_data, w_mem_data_next;
  logic [CNT_W-1:0]    r_p0_grants, w_p0_grants_next;
  logic [CNT_W-1:0]    r_p1_grants, w_p1_grants_next;

  logic                w_grant_valid;
  logic                w_grant_port;
  logic                w_ack_ok;

  // Round-robin: on a tie the port that did not win last time goes next.
  always_comb begin
    w_grant_valid = p0_enable_i | p1_enable_i;
    if (p0_enable_i && p1_enable_i) begin
      w_grant_port = ~r_last_grant;
    end else begin
      w_grant_port = p1_enable_i;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_mem_enable_next = r_mem_enable;
    w_mem_write_next  = r_mem_write;
    w_mem_addr_next   = r_mem_addr;
    w_mem_data_next   = r_mem_data;
    w_p0_grants_next  = r_p0_grants;
    w_p1_grants_next  = r_p1_grants;

    unique case (r_state)
      StIdle: begin
        w_mem_enable_next = 1'b0;
        if (w_grant_valid) begin
          w_last_grant_next = w_grant_port;
          w_mem_enable_next = 1'b1;
          w_state_next      = StBusy;
          if (w_grant_port) begin
            w_mem_write_next = p1_write_i;
            w_mem_addr_next  = p1_addr_i;
            w_mem_data_next  = p1_data_i;
          end else begin
            w_mem_write_next = p0_write_i;
            w_mem_addr_next  = p0_addr_i;
            w_mem_data_next  = p0_data_i;
          end
        end
      end
      StBusy: begin
        // Dropping the owner's enable does not abort; only mem_ack_i ends BUSY.
        if (mem_ack_i) begin
          w_mem_enable_next = 1'b0;
          w_mem_write_next  = 1'b0;
          w_state_next      = StIdle;
          if (r_last_grant) begin
            if (r_p1_grants != {CNT_W{1'b1}}) w_p1_grants_next = r_p1_grants + CNT_W'(1);
          end else begin
            if (r_p0_grants != {CNT_W{1'b1}}) w_p0_grants_next = r_p0_grants + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_p0_grants  <= '0;
      r_p1_grants  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_mem_enable <= w_mem_enable_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_data   <= w_mem_data_next;
      r_p0_grants  <= w_p0_grants_next;
      r_p1_grants  <= w_p1_grants_next;
    end
  end

  // An ack seen in IDLE is spurious and never reaches a cache.
  assign w_ack_ok = (r_state == StBusy) && mem_ack_i && !rst_i;
  assign p0_ack_o = w_ack_ok && !r_last_grant;
  assign p1_ack_o = w_ack_ok && r_last_grant;

  assign p0_data_o    = mem_data_i;
  assign p1_data_o    = mem_data_i;
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign p0_grants_o  = r_p0_grants;
  assign p1_grants_o  = r_p1_grants;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 256;
  localparam int unsigned CW = 2;
  localparam int          CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_en, p0_wr, p1_en, p1_wr;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic          p0_ack, p1_ack;
  logic          mem_en, mem_wr, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] p0_gr, p1_gr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(p0_en), .p0_write_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
    .p0_ack_o(p0_ack), .p0_data_o(p0_rdata),
    .p1_enable_i(p1_en), .p1_write_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_ack_o(p1_ack), .p1_data_o(p1_rdata),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .p0_grants_o(p0_gr), .p1_grants_o(p1_gr)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t q0[$];
  req_t q1[$];
  logic [AW-1:0] served[$];

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the memory (-1 = nobody), who wins the next tie,
  // the transaction presented to memory, and completed-transaction counts.
  int            m_owner = -1;
  int            m_pref = 0;
  logic          m_en = 1'b0, m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_cnt[2] = '{0, 0};

  // Bench-side memory and requester state.
  bit   auto_mem = 1'b1;
  bit   rand_lat = 1'b0;
  int   mem_lat = 10;
  int   lat_cnt = 0;
  bit   acked0 = 1'b0, acked1 = 1'b0;
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic req_t mk_req(input logic wr, input logic [AW-1:0] addr);
    req_t r;
    r.wr = wr;
    r.addr = addr;
    r.data = rand_line();
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom;
    a[4:0] = '0;
    return a;
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      m_owner = -1; m_pref = 0; m_en = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_data = '0; m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (m_owner < 0) begin
      w = -1;
      if (p0_en && p1_en) w = m_pref;
      else if (p0_en) w = 0;
      else if (p1_en) w = 1;
      if (w >= 0) begin
        m_owner = w;
        m_pref = 1 - w;
        m_en = 1'b1;
        m_wr   = (w == 1) ? p1_wr : p0_wr;
        m_addr = (w == 1) ? p1_addr : p0_addr;
        m_data = (w == 1) ? p1_wdata : p0_wdata;
      end
    end else if (mem_ack) begin
      if (m_cnt[m_owner] < CntMax) m_cnt[m_owner]++;
      m_owner = -1;
      m_en = 1'b0;
      m_wr = 1'b0;
    end
  endtask

  task automatic check_comb();
    chk("p0_ack", p0_ack, !rst && m_owner == 0 && mem_ack);
    chk("p1_ack", p1_ack, !rst && m_owner == 1 && mem_ack);
    chk("p0_data", p0_rdata, mem_rdata);
    chk("p1_data", p1_rdata, mem_rdata);
    acked0 = p0_ack;
    acked1 = p1_ack;
  endtask

  task automatic check_regs();
    chk("mem_enable", mem_en, m_en);
    chk("mem_write", mem_wr, m_wr);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_data", mem_wdata, m_data);
    chk("p0_grants", p0_gr, m_cnt[0]);
    chk("p1_grants", p1_gr, m_cnt[1]);
    if (mem_en && !prev_en) served.push_back(mem_addr);
    prev_en = mem_en;
  endtask

  task automatic mem_drive();
    mem_rdata = rand_line();
    if (!auto_mem) return;
    if (mem_en) begin
      lat_cnt++;
      if (lat_cnt >= mem_lat) begin
        mem_ack = 1'b1;
        lat_cnt = 0;
        if (rand_lat) mem_lat = $urandom_range(1, 4);
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end
  endtask

  // Each port presents the head of its queue; the head retires after its ack,
  // and a non-empty queue keeps enable high across the ack edge.
  task automatic req_drive();
    if (acked0 && q0.size() > 0) void'(q0.pop_front());
    if (acked1 && q1.size() > 0) void'(q1.pop_front());
    acked0 = 1'b0;
    acked1 = 1'b0;
    p0_en = q0.size() > 0;
    if (p0_en) begin p0_wr = q0[0].wr; p0_addr = q0[0].addr; p0_wdata = q0[0].data; end
    p1_en = q1.size() > 0;
    if (p1_en) begin p1_wr = q1[0].wr; p1_addr = q1[0].addr; p1_wdata = q1[0].data; end
  endtask

  task automatic tick();
    mem_drive();
    req_drive();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || mem_en) && n < max) begin
      tick();
      n++;
    end
    chk("drain_bound", n < max, 1'b1);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    acked0 = 1'b0;
    acked1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [CW-1:0] g0, g1;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    p0_en = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0;
    p1_en = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;

    // Reset state.
    do_reset();
    chk("rst_mem_enable", mem_en, 1'b0);
    chk("rst_p0_grants", p0_gr, '0);

    // Single dcache read, memory answers 10 cycles after enable rises.
    mem_lat = 10;
    q0.push_back(mk_req(1'b0, 32'h400));
    drain(40);
    chk("s1_addr", mem_addr, 32'h400);
    chk("s1_p0_grants", p0_gr, 1);

    // Simultaneous requests after reset: port 0 first.
    do_reset();
    served.delete();
    mem_lat = 3;
    q0.push_back(mk_req(1'b0, 32'h20));
    q1.push_back(mk_req(1'b0, 32'h1000));
    drain(40);
    chk("s2_count", served.size(), 2);
    if (served.size() == 2) begin
      chk("s2_first", served[0], 32'h20);
      chk("s2_second", served[1], 32'h1000);
    end
    chk("s2_p0_grants", p0_gr, 1);
    chk("s2_p1_grants", p1_gr, 1);

    // Write-back then refill while icache waits: p0 write, p1, p0 read.
    do_reset();
    served.delete();
    q0.push_back(mk_req(1'b1, 32'h800));
    q0.push_back(mk_req(1'b0, 32'hC00));
    q1.push_back(mk_req(1'b0, 32'h1400));
    drain(60);
    chk("s3_count", served.size(), 3);
    if (served.size() == 3) begin
      chk("s3_first", served[0], 32'h800);
      chk("s3_second", served[1], 32'h1400);
      chk("s3_third", served[2], 32'hC00);
    end
    chk("s3_p0_grants", p0_gr, 2);

    // Spurious ack in IDLE.
    g0 = p0_gr;
    g1 = p1_gr;
    auto_mem = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    auto_mem = 1'b1;
    chk("spur_p0_grants", p0_gr, g0);
    chk("spur_p1_grants", p1_gr, g1);

    // Reset while p1 is being served; late memory ack must be ignored.
    do_reset();
    mem_lat = 10;
    q1.push_back(mk_req(1'b0, 32'h2000));
    n = 0;
    while (!mem_en && n < 5) begin tick(); n++; end
    chk("s5_busy_reached", mem_en, 1'b1);
    tick();
    rst = 1'b1;
    q1.delete();
    tick();
    rst = 1'b0;
    chk("s5_enable_after_rst", mem_en, 1'b0);
    auto_mem = 1'b0;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    auto_mem = 1'b1;
    chk("s5_p1_grants", p1_gr, 0);
    mem_lat = 2;
    q0.push_back(mk_req(1'b1, 32'h40));
    drain(30);
    chk("s5_p0_grants", p0_gr, 1);

    // Counter saturation: five port-0 transactions on a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) q0.push_back(mk_req(i[0], rand_addr()));
    drain(80);
    chk("sat_p0_grants", p0_gr, 3);

    // Randomized traffic with random memory latency.
    do_reset();
    rand_lat = 1'b1;
    mem_lat = 2;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(mk_req($urandom_range(0, 1), rand_addr()));
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(mk_req($urandom_range(0, 1), rand_addr()));
      tick();
    end
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
